mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous `memory` between the `cpu` and a second master (debug/loader port driven from the switches). It sits between both masters and the memory's `we/addr/data/out` pins, all on the divided clock. It issues at most one access per cycle with round-robin fairness and routes the read data back to the requester that issued the read. An optional lock lets one master perform uninterrupted multi-access sequences such as read-modify-write.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state encoding,
// requester indices and the per-state eligibility mask.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   // While a master owns the memory only that master's request may compete.
   function automatic logic [1:0] own_mask(input arb_state_t state);
      case (state)
         ARB_OWN0: own_mask = 2'b01;
         ARB_OWN1: own_mask = 2'b10;
         default:  own_mask = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker. last=1 means requester 1 won most
// recently, so requester 0 takes the next tie. Grant is one-hot or zero.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);

   logic [1:0] eligible;

   assign eligible = req & mask;

   // NOTE: give every always_comb output a default first so no path can infer a latch.
   always_comb begin
      gnt = 2'b00;
      if (eligible == 2'b11) begin
         gnt = (last == REQ_DBG) ? 2'b01 : 2'b10;
      end else begin
         gnt = eligible;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the cpu (0) and the debug
// port (1). Optional ownership lock is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_out
);

   arb_state_t            state;
   logic                  last;
   logic                  rd_pend;
   logic                  rd_id;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic [1:0]            pick;
   logic                  accept;
   logic                  win_id;
   logic                  win_we;

   rr_pick2 u_pick (
      .req  ({req1, req0}),
      .last (last),
      .mask (own_mask(state)),
      .gnt  (pick)
   );

   // Nothing is granted while reset is held, so the memory sees no access.
   assign gnt0   = rst_n & pick[0];
   assign gnt1   = rst_n & pick[1];
   assign accept = gnt0 | gnt1;
   assign win_id = gnt1;
   assign win_we = gnt1 ? we1 : we0;

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      if (gnt0) begin
         mem_we   = we0;
         mem_addr = addr0;
         mem_data = wdata0;
      end else if (gnt1) begin
         mem_we   = we1;
         mem_addr = addr1;
         mem_data = wdata1;
      end
   end

   // Memory output is live in the cycle after the read edge; pass it through
   // then and hold it afterwards.
   assign rvalid0 = rd_pend & (rd_id == REQ_CPU);
   assign rvalid1 = rd_pend & (rd_id == REQ_DBG);
   assign rdata0  = rvalid0 ? mem_out : rdata0_q;
   assign rdata1  = rvalid1 ? mem_out : rdata1_q;

`ifndef MEM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = lock0 ^ lock1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         last     <= REQ_DBG;
         rd_pend  <= 1'b0;
         rd_id    <= REQ_CPU;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         rd_pend <= accept & ~win_we;
         if (accept) begin
            rd_id <= win_id;
            last  <= win_id;
         end
         if (rvalid0) rdata0_q <= mem_out;
         if (rvalid1) rdata1_q <= mem_out;

`ifdef MEM_ARB_LOCK_EN
         case (state)
            ARB_IDLE: begin
               if (accept && (gnt1 ? lock1 : lock0)) begin
                  state <= gnt1 ? ARB_OWN1 : ARB_OWN0;
               end
            end
            ARB_OWN0: if (!req0 || (gnt0 && !lock0)) state <= ARB_IDLE;
            ARB_OWN1: if (!req1 || (gnt1 && !lock1)) state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
`else
         state <= ARB_IDLE;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [5:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [15:0] mem_data;
   logic [15:0] mem_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_out(mem_out)
   );

   function automatic logic [15:0] init_val(input int a);
      if (a == 5) return 16'h00A5;
      return 16'((a * 977) ^ 16'h3C5A);
   endfunction

   // Single-port synchronous memory: output registered one cycle after address.
   logic [15:0] tb_mem [64];
   bit          written [64];
   always @(posedge clk) begin
      mem_out <= written[mem_addr] ? tb_mem[mem_addr] : init_val(int'(mem_addr));
      if (mem_we) begin
         tb_mem[mem_addr]  <= mem_data;
         written[mem_addr] <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: owner (-1 = nobody), who won last, and in-flight read.
   logic [15:0] ref_mem [64];
   int          owner;
   int          last_w;
   bit          pend_v;
   int          pend_id;
   logic [15:0] pend_data;
   logic [15:0] held [2];
   int          model_win;

   task automatic model_cycle();
      bit          e0, e1;
      int          win;
      logic        xwe, xlk;
      logic [5:0]  xa;
      logic [15:0] xd;
      bit          rv0, rv1;
      logic [15:0] rd0, rd1;

      e0 = rst_n && req0 && owner != 1;
      e1 = rst_n && req1 && owner != 0;
      win = -1;
      if (e0 && e1) win = (last_w == 1) ? 0 : 1;
      else if (e0) win = 0;
      else if (e1) win = 1;
      model_win = win;

      xwe = 0; xlk = 0; xa = 0; xd = 0;
      if (win == 0) begin xwe = we0; xlk = lock0; xa = addr0; xd = wdata0; end
      if (win == 1) begin xwe = we1; xlk = lock1; xa = addr1; xd = wdata1; end

      rv0 = pend_v && pend_id == 0;
      rv1 = pend_v && pend_id == 1;
      rd0 = rv0 ? pend_data : held[0];
      rd1 = rv1 ? pend_data : held[1];

      check("gnt0", 32'(gnt0), 32'(win == 0));
      check("gnt1", 32'(gnt1), 32'(win == 1));
      check("mem_we", 32'(mem_we), 32'(xwe));
      check("mem_addr", 32'(mem_addr), 32'(xa));
      check("mem_data", 32'(mem_data), 32'(xd));
      check("rvalid0", 32'(rvalid0), 32'(rv0));
      check("rvalid1", 32'(rvalid1), 32'(rv1));
      check("rdata0", 32'(rdata0), 32'(rd0));
      check("rdata1", 32'(rdata1), 32'(rd1));

      // What the coming clock edge commits.
      if (!rst_n) begin
         owner = -1; last_w = 1; pend_v = 0; held[0] = '0; held[1] = '0;
      end else begin
         held[0] = rd0;
         held[1] = rd1;
         pend_v = (win >= 0) && !xwe;
         if (win >= 0) begin
            pend_id   = win;
            pend_data = ref_mem[xa];
            if (xwe) ref_mem[xa] = xd;
            last_w = win;
`ifdef MEM_ARB_LOCK_EN
            owner = xlk ? win : -1;
`endif
         end else if ((owner == 0 && !req0) || (owner == 1 && !req1)) begin
            owner = -1;
         end
      end
   endtask

   task automatic drive(input logic rst,
                        input logic r0, input logic w0, input logic l0,
                        input logic [5:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [5:0] a1, input logic [15:0] d1);
      @(negedge clk);
      rst_n = rst;
      req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
      #2;
      model_cycle();
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Random traffic slots: a request is held until the model says it was taken.
   bit          has [2];
   logic        s_we [2];
   logic        s_lk [2];
   logic [5:0]  s_a [2];
   logic [15:0] s_d [2];

   initial begin
      owner = -1; last_w = 1; pend_v = 0; pend_id = 0; pend_data = '0;
      held[0] = '0; held[1] = '0; model_win = -1;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

      do_reset();
      idle();
      check("rst_rvalid0", 32'(rvalid0), 0);
      check("rst_rdata0", 32'(rdata0), 0);

      // Lone read of address 5 by the cpu.
      drive(1, 1, 0, 0, 6'd5, 0, 0, 0, 0, 0, 0);
      check("rd5_gnt0", 32'(gnt0), 1);
      check("rd5_addr", 32'(mem_addr), 5);
      idle();
      check("rd5_rvalid0", 32'(rvalid0), 1);
      check("rd5_rdata0", 32'(rdata0), 32'h00A5);
      check("rd5_rvalid1", 32'(rvalid1), 0);

      // Contention straight after reset alternates starting with the cpu.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 0, 6'd5, 0, 1, 0, 0, 6'd7, 0);
         check("alt_gnt0", 32'(gnt0), 32'(k % 2 == 0));
         if (k > 0) check("alt_rvalid0", 32'(rvalid0), 32'(k % 2 == 1));
      end
      idle();
      check("alt_last_rvalid1", 32'(rvalid1), 1);

      // Debug write then cpu read of the same word.
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 6'd10, 16'h1234);
      drive(1, 1, 0, 0, 6'd10, 0, 0, 0, 0, 0, 0);
      check("wr_no_rvalid1", 32'(rvalid1), 0);
      idle();
      check("raw_rdata0", 32'(rdata0), 32'h1234);

      // Debug read-modify-write of address 3 while the cpu keeps requesting.
      drive(1, 1, 0, 0, 6'd1, 0, 1, 0, 1, 6'd3, 0);
      check("lk_a_gnt1", 32'(gnt1), 1);
      drive(1, 1, 0, 0, 6'd1, 0, 1, 1, 0, 6'd3, 16'hBEEF);
`ifdef MEM_ARB_LOCK_EN
      check("lk_b_gnt0", 32'(gnt0), 0);
      check("lk_b_gnt1", 32'(gnt1), 1);
      drive(1, 1, 0, 0, 6'd1, 0, 0, 0, 0, 0, 0);
      check("lk_c_gnt0", 32'(gnt0), 1);
`else
      check("nolk_b_gnt0", 32'(gnt0), 1);
      drive(1, 1, 0, 0, 6'd1, 0, 1, 1, 0, 6'd3, 16'hBEEF);
      check("nolk_c_gnt1", 32'(gnt1), 1);
`endif
      idle();
      idle();

      // Reset while a read response is pending.
      drive(1, 1, 0, 0, 6'd5, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rstp_gnt0", 32'(gnt0), 0);
      check("rstp_mem_addr", 32'(mem_addr), 0);
      drive(1, 1, 0, 0, 6'd2, 0, 1, 0, 0, 6'd4, 0);
      check("rstp_rvalid0", 32'(rvalid0), 0);
      check("rstp_rdata0", 32'(rdata0), 0);
      check("rstp_tie_gnt0", 32'(gnt0), 1);
      idle();
      idle();

      // Randomized traffic with occasional locks and resets.
      has[0] = 0; has[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!has[i] && $urandom_range(0, 99) < 60) begin
               has[i]  = 1;
               s_we[i] = 1'($urandom_range(0, 1));
               s_lk[i] = ($urandom_range(0, 99) < 30);
               s_a[i]  = 6'($urandom_range(0, 15));
               s_d[i]  = 16'($urandom);
            end
         end
         drive(($urandom_range(0, 99) >= 2),
               has[0], s_we[0], s_lk[0], s_a[0], s_d[0],
               has[1], s_we[1], s_lk[1], s_a[1], s_d[1]);
         if (model_win >= 0) has[model_win] = 0;
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
